// File: rtl/fifo32_pkg.sv
// rtl/fifo32_pkg.sv - shared sizing constants, count type and pointer helper for fifo32
package fifo32_pkg;

  localparam int FIFO32_WIDTH      = 32;
  localparam int FIFO32_DEPTH_LOG2 = 3;
  localparam int FIFO32_DEPTH      = 1 << FIFO32_DEPTH_LOG2;

  // Occupancy needs one bit more than the pointers so that "8" is representable.
  typedef logic [FIFO32_DEPTH_LOG2:0]   fifo32_count_t;
  typedef logic [FIFO32_DEPTH_LOG2-1:0] fifo32_ptr_t;

  // Wrapping increment; the pointer width makes 7 -> 0 fall out naturally.
  function automatic fifo32_ptr_t fifo32_ptr_next(input fifo32_ptr_t ptr);
    return ptr + fifo32_ptr_t'(1);
  endfunction

endpackage

// File: rtl/fifo32_ptr.sv
// rtl/fifo32_ptr.sv - wrapping FIFO pointer with synchronous active-high reset and increment enable
module fifo32_ptr
  import fifo32_pkg::*;
#(
  parameter int W = FIFO32_DEPTH_LOG2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  // Next pointer: advance by one on an accepted operation, wrap at the top.
  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) begin
      ptr_d = ptr_q + W'(1);
    end
  end

  // Pointer register; reset wins over any increment in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo32.sv
// rtl/fifo32.sv - eight-entry synchronous FIFO with registered status; error flags built only with FIFO32_ERR_FLAGS_EN
module fifo32
  import fifo32_pkg::*;
#(
  parameter int WIDTH      = FIFO32_WIDTH,
  parameter int DEPTH_LOG2 = FIFO32_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      din,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   data_count,
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic                  rd_ack,
  output logic                  rd_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;

  logic [DEPTH_LOG2:0]   count_q;
  logic [DEPTH_LOG2:0]   count_d;
  logic                  full_q;
  logic                  full_d;
  logic                  empty_q;
  logic                  empty_d;
  logic [WIDTH-1:0]      dout_q;
  logic [WIDTH-1:0]      dout_d;
  logic                  wr_ack_q;
  logic                  rd_ack_q;

  logic                  wr_ok;
  logic                  rd_ok;

  // Acceptance is judged on the registered flags, i.e. the state before the edge.
  // Reset masks both so that a reset cycle touches neither memory nor dout.
  always_comb begin
    wr_ok = wr_en && !full_q  && !reset;
    rd_ok = rd_en && !empty_q && !reset;
  end

  fifo32_ptr #(.W(DEPTH_LOG2)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc_i (wr_ok),
    .ptr_o (wr_ptr)
  );

  fifo32_ptr #(.W(DEPTH_LOG2)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc_i (rd_ok),
    .ptr_o (rd_ptr)
  );

  // Next occupancy and status; full is simply the top bit since the count never exceeds DEPTH.
  always_comb begin
    count_d = count_q + (DEPTH_LOG2+1)'(wr_ok) - (DEPTH_LOG2+1)'(rd_ok);
    full_d  = count_d[DEPTH_LOG2];
    empty_d = (count_d == '0);
  end

  // Next read data: only an accepted read replaces the word on dout.
  always_comb begin
    dout_d = dout_q;
    if (rd_ok) begin
      dout_d = mem_q[rd_ptr];
    end
  end

  // Storage array; deliberately not reset, stale words are unreachable once the count is cleared.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr] <= din;
    end
  end

  // Count, status, read data and acknowledge registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      dout_q   <= '0;
      wr_ack_q <= 1'b0;
      rd_ack_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      dout_q   <= dout_d;
      wr_ack_q <= wr_ok;
      rd_ack_q <= rd_ok;
    end
  end

`ifdef FIFO32_ERR_FLAGS_EN
  logic wr_err_q;
  logic rd_err_q;

  // Error pulses: a request that arrived while the FIFO could not take it.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      wr_err_q <= wr_en && full_q;
      rd_err_q <= rd_en && empty_q;
    end
  end

  assign wr_err = wr_err_q;
  assign rd_err = rd_err_q;
`else
  assign wr_err = 1'b0;
  assign rd_err = 1'b0;
`endif

  assign dout       = dout_q;
  assign full       = full_q;
  assign empty      = empty_q;
  assign data_count = count_q;
  assign wr_ack     = wr_ack_q;
  assign rd_ack     = rd_ack_q;

endmodule

// File: tb/tb_fifo32.sv
// tb/tb_fifo32.sv - randomized and directed bench for fifo32 against a queue-based reference model
module tb_fifo32;
  import fifo32_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  wr_en;
  logic [31:0]           din;
  logic                  rd_en;
  logic [31:0]           dout;
  logic                  full;
  logic                  empty;
  fifo32_count_t         data_count;
  logic                  wr_ack;
  logic                  wr_err;
  logic                  rd_ack;
  logic                  rd_err;

  int total = 0;
  int bad   = 0;

  // Reference state
  logic [31:0] mq[$];
  logic [31:0] m_dout;
  logic        m_wr_ack, m_wr_err, m_rd_ack, m_rd_err;

  fifo32 dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .din        (din),
    .rd_en      (rd_en),
    .dout       (dout),
    .full       (full),
    .empty      (empty),
    .data_count (data_count),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus, advance the model, then compare every output.
  task automatic step(input logic w, input logic r, input logic [31:0] d, input logic rst);
    bit was_full, was_empty, wok, rok;
    wr_en = w; rd_en = r; din = d; reset = rst;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_dout = 32'h0;
      m_wr_ack = 0; m_wr_err = 0; m_rd_ack = 0; m_rd_err = 0;
    end else begin
      was_full  = (mq.size() == FIFO32_DEPTH);
      was_empty = (mq.size() == 0);
      wok = w && !was_full;
      rok = r && !was_empty;
      if (rok) m_dout = mq.pop_front();
      if (wok) mq.push_back(d);
      m_wr_ack = wok;
      m_rd_ack = rok;
`ifdef FIFO32_ERR_FLAGS_EN
      m_wr_err = w && !wok;
      m_rd_err = r && !rok;
`else
      m_wr_err = 0;
      m_rd_err = 0;
`endif
    end
    #1;
    chk("dout",  dout, m_dout);
    chk("count", data_count, mq.size());
    chk("full",  full, mq.size() == FIFO32_DEPTH);
    chk("empty", empty, mq.size() == 0);
    chk("wr_ack", wr_ack, m_wr_ack);
    chk("wr_err", wr_err, m_wr_err);
    chk("rd_ack", rd_ack, m_rd_ack);
    chk("rd_err", rd_err, m_rd_err);
  endtask

  localparam logic ERR_ON =
`ifdef FIFO32_ERR_FLAGS_EN
    1'b1;
`else
    1'b0;
`endif

  initial begin
    logic [31:0] v;
    wr_en = 0; rd_en = 0; din = 0; reset = 1;

    // Reset and idle
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("lit_rst_empty", empty, 1'b1);
    chk("lit_rst_full", full, 1'b0);
    chk("lit_rst_count", data_count, 0);
    chk("lit_rst_dout", dout, 32'h0);

    // Three writes then three reads
    step(1, 0, 32'h1234_5678, 0);
    chk("lit_empty_after_write", empty, 1'b0);
    step(1, 0, 32'h9876_5432, 0);
    step(1, 0, 32'hffee_ddcc, 0);
    step(0, 1, 0, 0);
    chk("lit_rd0", dout, 32'h1234_5678);
    chk("lit_ack0", rd_ack, 1'b1);
    step(0, 1, 0, 0);
    chk("lit_rd1", dout, 32'h9876_5432);
    step(0, 1, 0, 0);
    chk("lit_rd2", dout, 32'hffee_ddcc);
    chk("lit_empty3", empty, 1'b1);

    // Overflow: nine writes, then drain eight
    for (int i = 0; i < 9; i++) begin
      step(1, 0, i, 0);
      if (i == 7) chk("lit_full8", full, 1'b1);
    end
    chk("lit_ovf_count", data_count, 8);
    chk("lit_ovf_err", wr_err, ERR_ON);
    chk("lit_ovf_ack", wr_ack, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 0);
      chk("lit_drain", dout, i);
    end

    // Underflow and simultaneous access while empty
    step(0, 1, 0, 0);
    chk("lit_udf_dout", dout, 32'd7);
    chk("lit_udf_err", rd_err, ERR_ON);
    step(1, 1, 32'hbbaa_ccdd, 0);
    chk("lit_we_count", data_count, 1);
    chk("lit_we_rderr", rd_err, ERR_ON);
    step(0, 1, 0, 0);
    chk("lit_we_read", dout, 32'hbbaa_ccdd);

    // Simultaneous access while full, then steady-state at count 4
    for (int i = 0; i < 8; i++) step(1, 0, 32'hA000_0000 + i, 0);
    step(1, 1, 32'hdead_beef, 0);
    chk("lit_fb_count", data_count, 7);
    chk("lit_fb_dout", dout, 32'hA000_0000);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 1, $urandom, 0);
    chk("lit_steady_count", data_count, 4);

    // Reset mid-stream with a concurrent write
    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 32'h5000_0000 + i, 0);
    step(1, 0, 32'h7777_7777, 1);
    chk("lit_mrst_count", data_count, 0);
    chk("lit_mrst_ack", wr_ack, 1'b0);
    step(1, 0, 32'h0bad_cafe, 0);
    step(0, 1, 0, 0);
    chk("lit_mrst_read", dout, 32'h0bad_cafe);
    step(0, 1, 0, 0);
    chk("lit_mrst_empty", empty, 1'b1);

    // Random traffic with phases biased toward filling and draining
    for (int i = 0; i < 3000; i++) begin
      int bias;
      bias = ((i / 150) % 2 == 0) ? 70 : 30;
      v = $urandom;
      step($urandom_range(99) < bias, $urandom_range(99) >= bias - 20 ? 1'b1 : 1'b0, v,
           $urandom_range(399) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo32.md
# fifo32

Eight-entry, 32-bit-wide synchronous FIFO that sits directly downstream of the 32-bit register stage. It accepts the register's `q` word on a write strobe and releases words in order to the next consumer on a read strobe, with full/empty status, an occupancy count and per-operation acknowledge/error flags. Everything runs in a single clock domain; all outputs are registered.

## Interface
Parameters:
- `WIDTH`, 32: data word width.
- `DEPTH_LOG2`, 3: log2 of the entry count (8 entries).

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `wr_en`, in, 1: write request for `din`.
- `din`, in, WIDTH: write data, normally the upstream register `q`.
- `rd_en`, in, 1: read request.
- `dout`, out, WIDTH: registered read data.
- `full`, out, 1: count equals 8.
- `empty`, out, 1: count equals 0.
- `data_count`, out, DEPTH_LOG2+1: occupancy, 0 to 8.
- `wr_ack`, out, 1: the previous-edge write was accepted.
- `wr_err`, out, 1: the previous-edge write was rejected because the FIFO was full.
- `rd_ack`, out, 1: the previous-edge read was accepted and `dout` is new.
- `rd_err`, out, 1: the previous-edge read was rejected because the FIFO was empty.

## Operation
- Storage is an array of 8 × WIDTH words, with a 3-bit write pointer `wr_ptr` and a 3-bit read pointer `rd_ptr`. Both wrap naturally from 7 to 0.
- Write acceptance (`wr_ok`) is `wr_en && !full`.
  - On accept: write `mem[wr_ptr] <= din` and increment `wr_ptr`.
- Read acceptance (`rd_ok`) is `rd_en && !empty`.
  - On accept: `dout <= mem[rd_ptr]` and increment `rd_ptr`.
- `full` and `empty` are evaluated on the current registered state, before the edge.
  - Full with both `wr_en` and `rd_en`: the read is accepted, the write is rejected (`wr_err`=1), and the count drops by 1.
  - Empty with both `wr_en` and `rd_en`: the write is accepted, the read is rejected (`rd_err`=1), and the count rises by 1. No write-to-read bypass.
  - Both accepted: the count is unchanged and both pointers advance.
- Count update: `data_count <= data_count + wr_ok - rd_ok`. It never leaves the range 0..8.
- `full` and `empty` are registered and derived from the next count value, so they are always consistent with `data_count`.
- Acknowledge and error flags:
  - Registered, one-cycle pulses.
  - `wr_ack` and `wr_err` are mutually exclusive; both are 0 when `wr_en`=0. The same holds for `rd_ack` and `rd_err`.
- A rejected operation changes no pointer, no memory location and not `dout`. `dout` holds its last value when no read is accepted.
- No FSM. The state is the pointers plus the count.

## Timing
- Reset values, applied at the first rising edge with `reset`=1:
  - `wr_ptr`=0, `rd_ptr`=0, `data_count`=0.
  - `empty`=1, `full`=0.
  - `dout`=32'h0000_0000.
  - All ack and err flags 0.
  - Memory contents are not reset.
- `reset` has priority over `wr_en` and `rd_en` in the same cycle. Reset asserted mid-stream discards all stored words.
- Write latency: a word written at edge N is readable at edge N+1. `empty` deasserts after edge N.
- Read latency: with `rd_en` sampled at edge N, `dout` and `rd_ack` are valid after edge N, one register stage.
- Fall-through: none.

## Configuration
- Macro `FIFO32_ERR_FLAGS_EN`.
- Defined: `wr_err` and `rd_err` behave as described above.
- Undefined:
  - `wr_err` and `rd_err` are tied to 0 and their registers are not built.
  - Overflow and underflow requests are still silently ignored; `wr_ack` and `rd_ack` are unchanged.

## Structure
- Package `fifo32_pkg`:
  - `FIFO32_WIDTH`=32, `FIFO32_DEPTH_LOG2`=3, `FIFO32_DEPTH`=8.
  - A typedef for the count width, DEPTH_LOG2+1 bits.
- Sub-module `fifo32_ptr`:
  - A 3-bit wrapping pointer with synchronous active-high reset and an increment enable.
  - Instantiated twice, once for write and once for read.
- Count, flag and memory logic live in the top level.

## Test plan
- Reset, then idle -> `empty`=1, `full`=0, `data_count`=0, `dout`=0, all flags 0.
- Write 32'h1234_5678, 32'h9876_5432, 32'hffee_ddcc, then read 3 times -> `dout` sequence 1234_5678, 9876_5432, ffee_ddcc with `rd_ack`=1 on each; `empty`=1 after the third read.
- Write 9 words 0..8 -> `full`=1 after the 8th; the 9th gives `wr_err`=1 and `data_count` stays 8; reading 8 words returns 0..7.
- Read while empty -> `rd_err`=1, `dout` unchanged, count 0. Simultaneous `wr_en`+`rd_en` when empty with `din`=32'hbbaa_ccdd -> count 1, `rd_err`=1, and the next read returns bbaa_ccdd.
- Fill to 8, then simultaneous `wr_en`+`rd_en` -> read accepted, write rejected, count 7. Then run 20 cycles of simultaneous write and read at count 4 -> count stays 4, pointers wrap, and data order is preserved.
- Write 5 words, assert `reset` together with `wr_en` -> count 0, `empty`=1, no `wr_ack`; the next write then read returns only the new word.
